// File: rtl/sipo_frame_receiver_if.sv
// Parallel-side bus of the serial frame receiver: word, valid/ready handshake and status.
// The receiver drives the master modport; the consumer uses the slave modport.
interface sipo_frame_receiver_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              parity_err;
    logic              overrun;
    logic              busy;

    modport master (
        output data_out,
        output data_valid,
        output parity_err,
        output overrun,
        output busy,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  overrun,
        input  busy,
        output data_ready
    );
endinterface

// File: rtl/sipo_frame_receiver.sv
// Serial-to-parallel frame receiver: start bit, DATA_W data bits MSB-first, optional
// even parity, with a one-entry holding register behind a valid/ready handshake.
module sipo_frame_receiver #(
    parameter int DATA_W    = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  serial_in,
    input  logic                  shift_en,
    sipo_frame_receiver_if.master bus
);
    localparam int              CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_next;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic              frame_done;
    logic [DATA_W-1:0] word;
    logic              word_perr;

    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              perr_q;
    logic              overrun_q;
    logic              hold_free;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            shreg   <= shreg_next;
        end
    end

    // word/word_perr are only meaningful on the edge where frame_done is high
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        frame_done   = 1'b0;
        word         = shreg;
        word_perr    = 1'b0;
        if (shift_en) begin
            case (state)
                IDLE: begin
                    if (serial_in) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
                DATA: begin
                    shreg_next   = {shreg[DATA_W-2:0], serial_in};
                    bit_cnt_next = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_next = '0;
                        if (PARITY_EN) begin
                            state_next = PARITY;
                        end else begin
                            state_next = IDLE;
                            frame_done = 1'b1;
                            word       = shreg_next;
                        end
                    end
                end
                PARITY: begin
                    state_next = IDLE;
                    frame_done = 1'b1;
                    word       = shreg;
                    word_perr  = (^shreg) ^ serial_in;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign hold_free = !valid_q || bus.data_ready;

    // A completing frame may reuse the slot in the same edge it is being consumed
    always_ff @(posedge clk) begin
        if (rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else if (frame_done) begin
            if (hold_free) begin
                data_q  <= word;
                perr_q  <= word_perr;
                valid_q <= 1'b1;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (valid_q && bus.data_ready) begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.parity_err = PARITY_EN ? perr_q : 1'b0;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: doc/sipo_frame_receiver.md
Name: sipo_frame_receiver

Overview:
- Downstream consumer of the 8-bit SISO shift register's serial_out stream.
- Detects a start bit, deserialises DATA_W data bits MSB-first, and optionally checks an even-parity bit.
- Presents each word on a parallel output with a valid/ready handshake, a one-entry holding register and sticky error flags.

Parameters:
- DATA_W, 8: data bits per frame (legal range 2..32).
- PARITY_EN, 1: 1 = one even-parity bit follows the data; 0 = no parity bit, and parity_err is tied 0.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-high reset. A 1 sampled at a clk edge resets the block. The name is kept for consistency with the rest of the shift-register blocks.
- serial_in  input  1  serial line, sampled on clk edges where shift_en=1. Idle level is 0.
- shift_en  input  1  bit strobe. When 0, the FSM, bit counter and shift register hold.
- data_out  output  DATA_W  last completed word, MSB = first data bit received.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts data_out at an edge where data_valid=1.
- parity_err  output  1  parity result for the word currently in data_out.
- overrun  output  1  sticky. Set when a completed frame is dropped.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=1 at an edge), including mid-frame:
  - state=IDLE; bit counter=0; shift register=0.
  - data_out=0, data_valid=0, parity_err=0, overrun=0, busy=0.
  - Any partial frame is discarded.
- FSM states: IDLE, DATA, PARITY. All transitions below occur only on edges with shift_en=1.
  - IDLE: serial_in=1 is the start bit → DATA, counter=0. serial_in=0 → stay in IDLE.
  - DATA: shift serial_in into the LSB (left shift), counter+1. On the edge sampling bit DATA_W-1: → PARITY if PARITY_EN=1; otherwise complete the frame and → IDLE.
  - PARITY: sample the parity bit, complete the frame, → IDLE.
- Parity check:
  - Even parity: XOR of the DATA_W data bits and the parity bit must equal 0.
  - Mismatch → parity_err=1 for that word.
- Frame completion happens on the edge that samples the final bit (parity bit, or last data bit if PARITY_EN=0). On that same edge:
  - If the holding register is free (data_valid=0, or data_ready=1 this edge): data_out ← assembled word, parity_err ← result, data_valid ← 1. The word is visible right after that edge.
  - Otherwise the new word is dropped; data_out, data_valid and parity_err are unchanged, and overrun ← 1.
- Handshake:
  - A transfer occurs at an edge where data_valid=1 and data_ready=1.
  - With no simultaneous completion, data_valid drops at that edge. data_out retains its value. parity_err clears to 0.
  - Simultaneous transfer and completion: the new word loads, data_valid stays 1, and no overrun is raised.
  - data_ready is ignored while data_valid=0.
- busy is combinational from state (state≠IDLE).
- overrun clears only on reset.
- Back-to-back frames: a start bit may be sampled on the edge immediately after completion. There is no mandatory idle bit between frames.
- Total latency from start-bit edge to data_valid: DATA_W+1 enabled edges with parity, DATA_W without.
- shift_en=0 on any edge freezes the frame in progress. The handshake logic still operates on such edges.

Test Plan:
- Basic frame, DATA_W=8, PARITY_EN=1, shift_en=1, data_ready=0:
  - Stimulus: serial bits 1 | 1,0,1,1,1,1,0,1 | 0.
  - Required: after the 10th edge, data_out=0xBD, data_valid=1, parity_err=0, busy=0.
  - Then data_ready=1 for 1 cycle → data_valid=0.
- Parity error: same frame with parity bit 1 → data_out=0xBD, data_valid=1, parity_err=1.
- Overrun, data_ready held 0:
  - Stimulus: send 0xBD, then 0x3C with parity 0.
  - Required: data_out stays 0xBD, data_valid=1, overrun=1.
  - Then pulse rst_n → all outputs 0.
- Simultaneous completion and consume:
  - Stimulus: data_ready=1 exactly on the completion edge of frame 2 (0x3C) while 0xBD is pending.
  - Required: data_out=0x3C, data_valid=1, overrun=0.
- Reset mid-frame and shift_en gating:
  - Assert rst_n after 4 data bits → busy=0, no word produced.
  - Then a frame with shift_en toggling 1/0 every cycle → same 0xBD result after 10 enabled edges (20 clocks).
- PARITY_EN=0 instance:
  - Stimulus: 1 | 0,1,0,1,0,1,0,1.
  - Required: data_out=0x55, data_valid=1 after the 9th edge, parity_err=0.
